// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-wide register file. It inserts a fixed
// number of wait states per access and flags out-of-range addresses.
module apb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              pen,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              addrErr;
  logic [IDX_W-1:0]  rdIdx;

  // The full address decides the error, so aliased upper bits never reach the array.
  always_comb begin
    addrErr = (32'(paddr) >= DEPTH);
    rdIdx   = paddr[IDX_W-1:0];
  end

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && !pen) begin
            idx_q     <= rdIdx;
            write_q   <= pwrite;
            wdata_q   <= pwdata;
            err_q     <= addrErr;
            cnt_q     <= 4'(WAIT_STATES);
            pslverr_q <= addrErr;
            if (!pwrite) begin
              prdata_q <= addrErr ? '0 : mem_q[rdIdx];
            end
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          // Dropping psel abandons the transfer; nothing is committed.
          if (!psel) begin
            state_q <= IDLE;
          end else if (pen) begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              if (write_q && !err_q) begin
                mem_q[idx_q] <= wdata_q;
              end
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (slave) matching the 8-bit APB master interface used by the team's driver/monitor benches.
- Decodes setup/access phases and services transfers from an internal byte-wide register file.
- Inserts a programmable number of wait states via pready and flags out-of-range addresses with pslverr.
- Serves as the DUT-side responder that the existing APB driver and monitor run against.

Parameters:
- ADDR_W, 8, address width (matches paddr).
- DATA_W, 8, data width (matches pwdata/prdata).
- DEPTH, 256, number of implemented locations; addresses >= DEPTH are out of range.
- WAIT_STATES, 0, number of pready-low cycles inserted in each access phase (0..15).

Ports:
- pclk  input  1  clock, all logic on rising edge.
- prst  input  1  reset, synchronous, active-low.
- paddr  input  ADDR_W  transfer address.
- pwrite  input  1  1 = write, 0 = read.
- psel  input  1  slave select.
- pen  input  1  enable (access phase).
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data, valid while pready=1 on a read.
- pready  output  1  transfer complete / no wait.
- pslverr  output  1  error, valid only while pready=1.

Behaviour:
- Reset (prst=0 at a pclk edge): state IDLE, prdata=0, pslverr=0, wait counter=0, all DEPTH locations cleared to 0. pready=0 while in reset and after it.
- FSM states: IDLE, ACCESS.
- IDLE:
  - pready=0.
  - On edge with psel=1 && pen=0 (setup phase): latch paddr, pwrite and pwdata; load cnt=WAIT_STATES; compute err=(paddr>=DEPTH).
  - For a read without error, prdata<=mem[paddr]; for a read with error, prdata<=0. pslverr<=err.
  - Go to ACCESS.
  - psel=1 with pen=1 seen in IDLE (no setup phase) is ignored; stay in IDLE.
- ACCESS:
  - pready = (cnt==0), decoded from registered state and counter; no combinational path from inputs.
  - Each edge with psel=1, pen=1, cnt!=0: cnt<=cnt-1.
  - Edge with psel=1, pen=1, cnt==0 (transfer completes): if latched write and !err, mem[latched addr]<=latched pwdata. Go to IDLE.
  - Edge with psel=0: abort, no write, go to IDLE.
- Latency: with WAIT_STATES=W, pready rises in access cycle W+1. Total transfer time is 2+W cycles (setup + access).
- Address, direction and write data are taken from the setup-phase latch. Changes on paddr/pwdata during ACCESS have no effect.
- Back-to-back transfers: the setup cycle right after a completion is captured by IDLE at its end edge, so there is no lost cycle.
- prdata and pslverr hold their values until the next setup capture. pslverr is qualified by pready.
- Writes to an out-of-range address: memory is unchanged and pslverr=1 during the pready cycle.
- Reset in mid-transfer: abort, no memory update, outputs return to reset values.

Test Plan:
- Reset, WAIT_STATES=0; write 0xA5 to 0x10, then read 0x10 → during the read access cycle, pready=1, prdata=0xA5, pslverr=0; each transfer takes 2 cycles.
- WAIT_STATES=3; read 0x10 after writing 0x3C → pready low for 3 access cycles, high on the 4th with prdata=0x3C. A 0x77 written with 3 waits commits only at the pready edge.
- DEPTH=128; write 0x55 to 0x90, then read 0x90 → pslverr=1 with pready on both transfers, prdata=0x00; location 0x10 (index 0x10 of 128) is unchanged.
- Back-to-back writes 0x01→0x00, 0x02→0x01, 0x03→0x02 followed by reads → read data 0x01, 0x02, 0x03; no idle cycles are required between transfers.
- psel dropped after 1 of 3 wait cycles during a write of 0xEE to 0x20 → pready never rises; a later read of 0x20 returns the prior value.
- prst=0 asserted during ACCESS of a write, then read 0x10 → prdata=0x00 (memory cleared); pready=0 during reset.
